in_ctrl: RTL and testbench

Input-side controller for the two-operand calculator. Conditions the raw push-buttons, captures operand A and operand B from the switch bank, and computes and latches the result. Drives the 2-bit `estate` code and the `mem1`/`mem2`/`result` registers that the display output controller consumes. All outputs are registered on the rising edge of `clk`, so they are stable when the output controller samples them on the falling edge.

---
 rtl/calc_pkg.sv | 33 +++
 rtl/btn_debounce.sv | 88 ++++++++
 rtl/in_ctrl.sv | 161 ++++++++++++++++
 tb/tb_in_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// ============================================================================
// Module      : calc_pkg
// Description : Shared definitions for the two-operand calculator. Holds the
//               display state encoding used by both the input controller and
//               the output controller, and the operation select codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_pkg;

    // Display state encoding (visible on estate)
    localparam logic [1:0] ST_ENTER_A  = 2'b00;
    localparam logic [1:0] ST_ENTER_B  = 2'b01;
    localparam logic [1:0] ST_SHOW_RES = 2'b10;
    localparam logic [1:0] ST_ERROR    = 2'b11;

    // Operation select codes (op_sel)
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_ENTER_A  = ST_ENTER_A,
        S_ENTER_B  = ST_ENTER_B,
        S_SHOW_RES = ST_SHOW_RES,
        S_ERROR    = ST_ERROR
    } state_t;

endpackage : calc_pkg

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : Conditions one raw push-button: 2-flop synchronizer, debounce
//               counter and rising-edge detector. Emits a one-cycle pulse on
//               each accepted press.
// Ports       : clk     - system clock
//               rst     - asynchronous active-high reset
//               btn_raw - raw, bouncing, active-high button
//               press_p - one-cycle pulse per accepted press
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press_p
);

    localparam int                 CNT_W   = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             vld1_q, vld2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc_q, acc_d;
    logic             acc_dly_q;
    logic             armed_q, armed_d;

    // The valid pipeline marks when the synchronizer holds a real sample
    // rather than its reset value. Until then nothing is debounced.
    //
    // After reset the path is disarmed: it must first see the button
    // released for DEB_CYCLES consecutive cycles, so a press still held
    // through reset release never produces a pulse.
    always_comb begin
        cnt_d   = '0;
        acc_d   = acc_q;
        armed_d = armed_q;
        if (vld2_q) begin
            if (!armed_q) begin
                if (!sync2_q) begin
                    if (cnt_q == CNT_MAX) begin
                        armed_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end else if (sync2_q != acc_q) begin
                if (cnt_q == CNT_MAX) begin
                    acc_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            vld1_q    <= 1'b0;
            vld2_q    <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= 1'b0;
            acc_dly_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            vld1_q    <= 1'b1;
            vld2_q    <= vld1_q;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            acc_dly_q <= acc_q;
            armed_q   <= armed_d;
        end
    end

    assign press_p = acc_q & ~acc_dly_q;

endmodule : btn_debounce

`default_nettype wire

// File: rtl/in_ctrl.sv
// ============================================================================
// Module      : in_ctrl
// Description : Input-side controller of the two-operand calculator. Debounces
//               enter/clear, captures operands A and B from the switches,
//               computes and latches the result, and drives the display state.
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               sw[WIDTH]           - operand switches
//               op_sel[2]           - 00 add, 01 sub, 10 mul, 11 div
//               btn_enter/btn_clear - raw bouncing buttons
//               estate[2]           - display state code
//               mem1/mem2/result    - operand A, operand B, result
//               err                 - high while in ERROR
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module in_ctrl
    import calc_pkg::*;
#(
    parameter int DEB_CYCLES = 250000,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic [1:0]       op_sel,
    input  logic             btn_enter,
    input  logic             btn_clear,
    output logic [1:0]       estate,
    output logic [WIDTH-1:0] mem1,
    output logic [WIDTH-1:0] mem2,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    logic enter_p, clear_p;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_enter (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_enter),
        .press_p (enter_p)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_clear),
        .press_p (clear_p)
    );

    // Unsigned ALU; returns {error, value}.
    function automatic logic [WIDTH:0] alu(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic [1:0]       op);
        logic [WIDTH:0]     sum;
        logic [2*WIDTH-1:0] prod;
        logic               e;
        logic [WIDTH-1:0]   v;
        sum  = {1'b0, a} + {1'b0, b};
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        e    = 1'b0;
        v    = '0;
        case (op)
            OP_ADD: begin
                e = sum[WIDTH];
                v = sum[WIDTH-1:0];
            end
            OP_SUB: begin
                e = (a < b);
                v = a - b;
            end
            OP_MUL: begin
                e = |prod[2*WIDTH-1:WIDTH];
                v = prod[WIDTH-1:0];
            end
            default: begin
                e = (b == '0);
                v = e ? '0 : (a / b);
            end
        endcase
        return {e, v};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem1_q, mem1_d;
    logic [WIDTH-1:0] mem2_q, mem2_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             err_q, err_d;
    logic [WIDTH:0]   alu_out;

    // B is taken straight from the switches so the result is computed in
    // the same cycle that B is captured.
    assign alu_out = alu(mem1_q, sw, op_sel);

    always_comb begin
        state_d = state_q;
        mem1_d  = mem1_q;
        mem2_d  = mem2_q;
        res_d   = res_q;
        err_d   = err_q;
        // Clear takes precedence over a coincident enter.
        if (clear_p) begin
            state_d = S_ENTER_A;
            mem1_d  = '0;
            mem2_d  = '0;
            res_d   = '0;
            err_d   = 1'b0;
        end else if (enter_p) begin
            case (state_q)
                S_ENTER_A: begin
                    mem1_d  = sw;
                    state_d = S_ENTER_B;
                end
                S_ENTER_B: begin
                    mem2_d = sw;
                    if (alu_out[WIDTH]) begin
                        res_d   = '0;
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        res_d   = alu_out[WIDTH-1:0];
                        state_d = S_SHOW_RES;
                    end
                end
                default: begin
                    state_d = S_ENTER_A;
                    mem1_d  = '0;
                    mem2_d  = '0;
                    res_d   = '0;
                    err_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_ENTER_A;
            mem1_q  <= '0;
            mem2_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mem1_q  <= mem1_d;
            mem2_q  <= mem2_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign estate = state_q;
    assign mem1   = mem1_q;
    assign mem2   = mem2_q;
    assign result = res_q;
    assign err    = err_q;

endmodule : in_ctrl

`default_nettype wire

// File: tb/tb_in_ctrl.sv
// ============================================================================
// Module      : tb_in_ctrl
// Description : Self-checking bench for in_ctrl: directed vector table,
//               randomized operations against an integer reference model,
//               and hand-written bounce / clear / reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_in_ctrl;

    localparam int DEB   = 4;
    localparam int W     = 8;
    localparam int HOLD  = DEB + 8;
    localparam int MAXV  = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw = '0;
    logic [1:0]   op_sel = 2'b00;
    logic         btn_enter = 1'b0;
    logic         btn_clear = 1'b0;
    logic [1:0]   estate;
    logic [W-1:0] mem1, mem2, result;
    logic         err;

    int checks   = 0;
    int failures = 0;
    int nchg     = 0;
    logic [1:0] prev_st = 2'b00;

    in_ctrl #(.DEB_CYCLES(DEB), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .op_sel    (op_sel),
        .btn_enter (btn_enter),
        .btn_clear (btn_clear),
        .estate    (estate),
        .mem1      (mem1),
        .mem2      (mem2),
        .result    (result),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Counts estate changes seen on falling edges.
    always @(negedge clk) begin
        if (estate !== prev_st) nchg = nchg + 1;
        prev_st = estate;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int m1, input int m2,
                           input int r, input int e);
        chk({tag, ".estate"}, int'(estate), st);
        chk({tag, ".mem1"},   int'(mem1),   m1);
        chk({tag, ".mem2"},   int'(mem2),   m2);
        chk({tag, ".result"}, int'(result), r);
        chk({tag, ".err"},    int'(err),    e);
    endtask

    // Clean press: hold long enough to be accepted, then release long enough
    // for the release to be accepted too. Ends on a falling edge.
    task automatic press(input bit en, input bit cl);
        btn_enter = en;
        btn_clear = cl;
        repeat (HOLD) @(negedge clk);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    task automatic ref_calc(input int a, input int b, input int op,
                            output int st, output int r, output int e);
        int v;
        e = 0;
        v = 0;
        case (op)
            0: begin v = a + b; e = (v > MAXV) ? 1 : 0; end
            1: begin v = a - b; e = (a < b)    ? 1 : 0; end
            2: begin v = a * b; e = (v > MAXV) ? 1 : 0; end
            default: begin
                e = (b == 0) ? 1 : 0;
                v = (b == 0) ? 0 : a / b;
            end
        endcase
        st = e ? 3 : 2;
        r  = e ? 0 : v;
    endtask

    // A full A / B / acknowledge cycle with checks after every press.
    task automatic run_op(input string tag, input int a, input int b, input int op,
                          input int exp_st, input int exp_r);
        sw = W'(a);
        press(1'b1, 1'b0);
        chk_all({tag, ".A"}, 1, a, 0, 0, 0);
        sw     = W'(b);
        op_sel = 2'(op);
        press(1'b1, 1'b0);
        // Switch/op changes after capture must not disturb anything.
        sw     = W'($urandom);
        op_sel = 2'($urandom);
        repeat (3) @(negedge clk);
        chk_all({tag, ".B"}, exp_st, a, b, exp_r, (exp_st == 3) ? 1 : 0);
        press(1'b1, 1'b0);
        chk_all({tag, ".ack"}, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        int a;
        int b;
        int op;
        int exp_st;
        int exp_r;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int st, r, e, a, b, op;

        vecs[0] = '{25, 17, 0, 2, 42};
        vecs[1] = '{20, 13, 2, 3, 0};
        vecs[2] = '{15, 17, 2, 2, 255};
        vecs[3] = '{5,   9, 1, 3, 0};
        vecs[4] = '{200, 0, 3, 3, 0};
        vecs[5] = '{200, 7, 3, 2, 28};
        vecs[6] = '{200, 56, 0, 3, 0};
        vecs[7] = '{255, 0, 0, 2, 255};
        vecs[8] = '{9,   9, 1, 2, 0};
        vecs[9] = '{0,   5, 3, 2, 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;
        repeat (HOLD) @(negedge clk);

        // Bounce rejection: 2-cycle toggles, then a solid hold.
        nchg = 0;
        for (int i = 0; i < 10; i++) begin
            btn_enter = 1'b1;
            repeat (2) @(negedge clk);
            btn_enter = 1'b0;
            repeat (2) @(negedge clk);
        end
        chk("bounce.nochange", nchg, 0);
        btn_enter = 1'b1;
        repeat (10) @(negedge clk);
        btn_enter = 1'b0;
        repeat (HOLD) @(negedge clk);
        chk("bounce.changes", nchg, 1);
        chk("bounce.estate", int'(estate), 1);
        press(1'b0, 1'b1);
        chk_all("bounce.clear", 0, 0, 0, 0, 0);

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
                   vecs[i].exp_st, vecs[i].exp_r);
        end

        // Randomized operations against the reference model
        for (int i = 0; i < 16; i++) begin
            a  = int'($urandom_range(0, MAXV));
            b  = int'($urandom_range(0, (i % 4 == 3) ? 15 : MAXV));
            op = int'($urandom_range(0, 3));
            if (i % 5 == 0) a = int'($urandom_range(0, 15));
            ref_calc(a, b, op, st, r, e);
            run_op($sformatf("rnd%0d", i), a, b, op, st, r);
        end

        // Clear priority: enter and clear together while in ENTER_B.
        sw = 8'd99;
        press(1'b1, 1'b0);
        chk("clr.mem1_pre", int'(mem1), 99);
        sw = 8'd42;
        press(1'b1, 1'b1);
        chk_all("clr", 0, 0, 0, 0, 0);

        // Clear alone from SHOW_RES
        sw = 8'd3;
        press(1'b1, 1'b0);
        sw = 8'd4;
        op_sel = 2'b10;
        press(1'b1, 1'b0);
        chk("clr2.pre", int'(result), 12);
        press(1'b0, 1'b1);
        chk_all("clr2", 0, 0, 0, 0, 0);

        // Asynchronous reset while in SHOW_RES, between clock edges.
        sw = 8'd25;
        press(1'b1, 1'b0);
        sw = 8'd17;
        op_sel = 2'b00;
        press(1'b1, 1'b0);
        chk("arst.pre", int'(estate), 2);
        btn_enter = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_all("arst", 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nchg = 0;
        repeat (30) @(negedge clk);
        chk("arst.held", nchg, 0);
        btn_enter = 1'b0;
        repeat (HOLD) @(negedge clk);
        chk("arst.release", int'(estate), 0);
        sw = 8'd7;
        press(1'b1, 1'b0);
        chk("arst.repress", int'(estate), 1);
        chk("arst.mem1", int'(mem1), 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_in_ctrl

`default_nettype wire
